// File: rtl/pattern_pkg.sv
// pattern_pkg: shared types and constants for the pattern loader.
//   state_e        - loader FSM states
//   TS_W/PAT_W/REC_W - field widths of a pattern-memory record
//   ADDR_PATTERN   - register select used for every record write
//   pattern_rec_t  - {timestamp, pattern} record as stored in memory
package pattern_pkg;

    localparam int TS_W  = 10;
    localparam int PAT_W = 8;
    localparam int REC_W = TS_W + PAT_W;

    localparam logic [1:0] ADDR_PATTERN = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        TS_HI,
        TS_LO,
        PAT,
        CHK,
        WRITE
    } state_e;

    typedef struct packed {
        logic [TS_W-1:0]  timestamp;
        logic [PAT_W-1:0] pattern;
    } pattern_rec_t;

endpackage

// File: rtl/pattern_chk.sv
// pattern_chk: running XOR of the bytes of one frame.
//   clk_i, rst_n_i - clock, async active-low reset
//   clear_i        - restart the accumulation (takes priority over update_i)
//   update_i       - fold data_i into the accumulator
//   data_i         - byte to fold in
//   acc_o          - current XOR of all bytes folded since the last clear
module pattern_chk #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         clear_i,
    input  logic         update_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] acc_o
);

    logic [W-1:0] acc_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc_q <= '0;
        end else if (clear_i) begin
            acc_q <= '0;
        end else if (update_i) begin
            acc_q <= acc_q ^ data_i;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/pattern_loader.sv
// pattern_loader: parses framed records from a byte stream and writes each
// valid one to the pattern memory as {timestamp[9:0], pattern[7:0]}.
//
// Frame: SYNC_BYTE, TS_HI (only [1:0] used, [7:2] must be 0), TS_LO, PAT
//        and, with PATTERN_LOADER_CHECKSUM_EN defined, CHK = TS_HI^TS_LO^PAT.
//
// Ports:
//   CLOCK50M, RESET_N       - clock, async active-low reset
//   in_data/in_valid/in_ready - byte input handshake
//   clear_err               - clears frame_err (a new error in the same cycle wins)
//   write/address/pattern_with_timestamp - pattern-memory write port
//   busy                    - FSM not idle
//   frame_err               - sticky malformed-frame flag
//   record_count            - records written, saturating
//
// Build option: PATTERN_LOADER_CHECKSUM_EN adds the CHK byte and its check.
//
// state | meaning
// IDLE  | hunting for SYNC_BYTE, other bytes dropped
// TS_HI | expecting timestamp[9:8]
// TS_LO | expecting timestamp[7:0]
// PAT   | expecting pattern byte
// CHK   | expecting checksum byte (checksum build only)
// WRITE | one-cycle write strobe, input stalled
module pattern_loader
    import pattern_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         CNT_W     = 10
) (
    input  logic             CLOCK50M,
    input  logic             RESET_N,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             clear_err,
    output logic             write,
    output logic [1:0]       address,
    output logic [REC_W-1:0] pattern_with_timestamp,
    output logic             busy,
    output logic             frame_err,
    output logic [CNT_W-1:0] record_count
);

    state_e       state_q;
    pattern_rec_t rec_q;
    logic         frame_err_q;
    logic [CNT_W-1:0] cnt_q;
    logic         accept;

    assign in_ready = (state_q != WRITE);
    assign accept   = in_valid && in_ready;

`ifdef PATTERN_LOADER_CHECKSUM_EN
    logic [7:0] chk_acc;
    logic       chk_clear;
    logic       chk_update;

    assign chk_clear  = accept && (state_q == IDLE) && (in_data == SYNC_BYTE);
    assign chk_update = accept && ((state_q == TS_HI) || (state_q == TS_LO) || (state_q == PAT));

    pattern_chk #(.W(8)) u_chk (
        .clk_i    (CLOCK50M),
        .rst_n_i  (RESET_N),
        .clear_i  (chk_clear),
        .update_i (chk_update),
        .data_i   (in_data),
        .acc_o    (chk_acc)
    );
`endif

    always_ff @(posedge CLOCK50M or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            rec_q       <= '0;
            frame_err_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            // Clear first so that an error raised below in the same cycle overrides it.
            if (clear_err) begin
                frame_err_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (accept && (in_data == SYNC_BYTE)) begin
                        state_q <= TS_HI;
                    end
                end
                TS_HI: begin
                    if (accept) begin
                        if (|in_data[7:2]) begin
                            frame_err_q <= 1'b1;
                            state_q     <= IDLE;
                        end else begin
                            rec_q.timestamp[TS_W-1:8] <= in_data[1:0];
                            state_q                   <= TS_LO;
                        end
                    end
                end
                TS_LO: begin
                    if (accept) begin
                        rec_q.timestamp[7:0] <= in_data;
                        state_q              <= PAT;
                    end
                end
                PAT: begin
                    if (accept) begin
                        rec_q.pattern <= in_data;
`ifdef PATTERN_LOADER_CHECKSUM_EN
                        state_q <= CHK;
`else
                        state_q <= WRITE;
`endif
                    end
                end
`ifdef PATTERN_LOADER_CHECKSUM_EN
                CHK: begin
                    if (accept) begin
                        if (in_data == chk_acc) begin
                            state_q <= WRITE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= IDLE;
                        end
                    end
                end
`endif
                WRITE: begin
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign write                  = (state_q == WRITE);
    assign address                = ADDR_PATTERN;
    assign pattern_with_timestamp = rec_q;
    assign busy                   = (state_q != IDLE);
    assign frame_err              = frame_err_q;
    assign record_count           = cnt_q;

endmodule

// File: tb/tb_pattern_loader.sv
// tb_pattern_loader: directed and randomized checks of pattern_loader against
// a byte-stream reference model. A second instance with CNT_W=2 shares all
// inputs and is used to observe counter saturation.
// Honours PATTERN_LOADER_CHECKSUM_EN the same way as the design.
module tb_pattern_loader;

    localparam logic [7:0] SYNC = 8'hA5;
`ifdef PATTERN_LOADER_CHECKSUM_EN
    localparam int FRAME_LEN = 5;
`else
    localparam int FRAME_LEN = 4;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        clear_err;

    logic        in_ready, write, busy, frame_err;
    logic [1:0]  address;
    logic [17:0] pwt;
    logic [9:0]  record_count;

    logic        s_in_ready, s_write, s_busy, s_frame_err;
    logic [1:0]  s_address;
    logic [17:0] s_pwt;
    logic [1:0]  s_record_count;

    always #10 clk = ~clk;

    pattern_loader dut (
        .CLOCK50M               (clk),
        .RESET_N                (rst_n),
        .in_data                (in_data),
        .in_valid               (in_valid),
        .in_ready               (in_ready),
        .clear_err              (clear_err),
        .write                  (write),
        .address                (address),
        .pattern_with_timestamp (pwt),
        .busy                   (busy),
        .frame_err              (frame_err),
        .record_count           (record_count)
    );

    pattern_loader #(.CNT_W(2)) dut_sat (
        .CLOCK50M               (clk),
        .RESET_N                (rst_n),
        .in_data                (in_data),
        .in_valid               (in_valid),
        .in_ready               (s_in_ready),
        .clear_err              (clear_err),
        .write                  (s_write),
        .address                (s_address),
        .pattern_with_timestamp (s_pwt),
        .busy                   (s_busy),
        .frame_err              (s_frame_err),
        .record_count           (s_record_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference model: bytes of the frame being collected, plus expected outputs.
    logic [7:0]  frame_q[$];
    bit          m_wr;
    logic [17:0] m_rec;
    int          m_cnt;
    bit          m_err;
    int          ready_low_cnt;
    int          writes_seen;

    function automatic int sat3(input int c);
        return (c > 3) ? 3 : c;
    endfunction

    task automatic model_reset();
        frame_q.delete();
        m_wr  = 0;
        m_cnt = 0;
        m_err = 0;
    endtask

    task automatic model_byte(input logic [7:0] b, output bit err_ev);
        bit ok;
        err_ev = 0;
        if (frame_q.size() == 0) begin
            if (b == SYNC) frame_q.push_back(b);
        end else begin
            frame_q.push_back(b);
            if (frame_q.size() == 2 && b[7:2] != 6'd0) begin
                err_ev = 1;
                frame_q.delete();
            end else if (frame_q.size() == FRAME_LEN) begin
                ok = 1;
`ifdef PATTERN_LOADER_CHECKSUM_EN
                ok = (frame_q[4] == (frame_q[1] ^ frame_q[2] ^ frame_q[3]));
`endif
                if (ok) begin
                    m_wr  = 1;
                    m_rec = {frame_q[1][1:0], frame_q[2], frame_q[3]};
                end else begin
                    err_ev = 1;
                end
                frame_q.delete();
            end
        end
    endtask

    task automatic check_outputs();
        check_eq("write", write, m_wr);
        check_eq("in_ready", in_ready, !m_wr);
        check_eq("busy", busy, (frame_q.size() != 0) || m_wr);
        check_eq("frame_err", frame_err, m_err);
        check_eq("record_count", record_count, m_cnt);
        check_eq("address", address, 0);
        check_eq("sat_write", s_write, m_wr);
        check_eq("sat_in_ready", s_in_ready, !m_wr);
        check_eq("sat_busy", s_busy, (frame_q.size() != 0) || m_wr);
        check_eq("sat_frame_err", s_frame_err, m_err);
        check_eq("sat_record_count", s_record_count, sat3(m_cnt));
        check_eq("sat_address", s_address, 0);
        if (m_wr) begin
            check_eq("record", pwt, m_rec);
            check_eq("sat_record", s_pwt, m_rec);
        end
        if (!in_ready) ready_low_cnt++;
        if (write) writes_seen++;
    endtask

    // One clock cycle, entered and left just after a falling edge.
    task automatic cycle(input bit v, input logic [7:0] d, input bit clr, output bit acc);
        bit err_ev;
        in_valid  = v;
        in_data   = d;
        clear_err = clr;
        #1;
        check_outputs();
        acc = v && !m_wr;
        if (m_wr) m_cnt++;
        m_wr   = 0;
        err_ev = 0;
        if (acc) model_byte(d, err_ev);
        if (err_ev) m_err = 1;
        else if (clr) m_err = 0;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(0, 8'h00, 0, acc);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit clr);
        bit acc;
        int tries;
        tries = 0;
        do begin
            cycle(1, b, clr, acc);
            tries++;
        end while (!acc && tries < 8);
        if (!acc) check_eq("accept_timeout", acc, 1);
    endtask

    task automatic send_frame(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] pat,
                              input bit bad_chk, input bit gaps);
        logic [7:0] bytes[5];
        bytes[0] = SYNC;
        bytes[1] = hi;
        bytes[2] = lo;
        bytes[3] = pat;
        bytes[4] = hi ^ lo ^ pat ^ (bad_chk ? 8'h01 : 8'h00);
        for (int i = 0; i < FRAME_LEN; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) idle(1);
            send_byte(bytes[i], 0);
        end
    endtask

    task automatic apply_reset(input int hold);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("rst_write", write, 0);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_frame_err", frame_err, 0);
        check_eq("rst_record_count", record_count, 0);
        check_eq("rst_address", address, 0);
        check_eq("rst_record", pwt, 0);
        check_eq("rst_sat_record", s_pwt, 0);
        repeat (hold) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        bit acc;
        logic [7:0] hi, lo, pat;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        clear_err = 1'b0;
        ready_low_cnt = 0;
        writes_seen   = 0;
        @(negedge clk);
        apply_reset(2);

        // Basic record, then check the output holds after the strobe.
        send_frame(8'h01, 8'h23, 8'h5C, 0, 0);
        idle(3);
        check_eq("record_hold", pwt, 18'h1235C);

        // Timestamp high byte with reserved bits set, then clear.
        send_byte(SYNC, 0);
        send_byte(8'h04, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        idle(2);
        cycle(0, 8'h00, 1, acc);
        idle(1);

        // Error and clear in the same cycle: error must win.
        send_byte(SYNC, 0);
        send_byte(8'hFC, 1);
        idle(1);
        cycle(0, 8'h00, 1, acc);

        // Leading junk is dropped; max timestamp.
        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        send_frame(8'h03, 8'hFF, 8'h80, 0, 0);
        idle(2);
        check_eq("record_hold_max", pwt, 18'h3FF80);

        // Sync value inside a frame is plain data; zero pattern is legal.
        send_frame(8'h02, SYNC, 8'h00, 0, 0);
        idle(1);

`ifdef PATTERN_LOADER_CHECKSUM_EN
        send_frame(8'h01, 8'h23, 8'h5C, 0, 0);
        idle(1);
        send_frame(8'h01, 8'h23, 8'h5C, 1, 0);
        idle(2);
        cycle(0, 8'h00, 1, acc);
`endif

        // Back-to-back streaming and counter saturation.
        apply_reset(1);
        ready_low_cnt = 0;
        writes_seen   = 0;
        for (int f = 0; f < 3; f++) send_frame(8'h01, 8'(f), 8'(8'h10 + f), 0, 0);
        idle(2);
        check_eq("stream_ready_low", ready_low_cnt, 3);
        check_eq("stream_writes", writes_seen, 3);
        for (int f = 0; f < 2; f++) send_frame(8'h02, 8'(f), 8'h33, 0, 0);
        idle(2);
        check_eq("sat_count_final", s_record_count, 3);
        check_eq("count_final", record_count, 5);

        // Reset in the middle of a frame.
        send_byte(SYNC, 0);
        send_byte(8'h01, 0);
        send_byte(8'h23, 0);
        apply_reset(2);
        idle(2);
        send_frame(8'h00, 8'h45, 8'h67, 0, 0);
        idle(2);
        check_eq("after_reset_record", pwt, 18'h04567);

        // Randomized traffic.
        for (int it = 0; it < 250; it++) begin
            case ($urandom_range(0, 5))
                0: send_byte(8'($urandom_range(0, 255)), 0);
                1: cycle(0, 8'h00, ($urandom_range(0, 1) == 1), acc);
                default: begin
                    hi  = 8'($urandom_range(0, 3));
                    if ($urandom_range(0, 5) == 0) hi = hi | 8'($urandom_range(1, 63) << 2);
                    lo  = 8'($urandom_range(0, 255));
                    pat = 8'($urandom_range(0, 255));
                    send_frame(hi, lo, pat, ($urandom_range(0, 4) == 0), ($urandom_range(0, 1) == 1));
                end
            endcase
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
